// File: rtl/sw_debounce8.sv
// Joint debouncer for an 8-bit slide-switch vector plus enable switch.
// Feeds a priority encoder with clean, flop-driven code/enable and an update strobe.
module sw_debounce8 #(
    parameter logic [19:0] DEB_CYCLES = 20'd1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_sw,
    input  logic       i_en_raw,
    output logic [7:0] o_code,
    output logic       o_en,
    output logic       o_chg,
    output logic       o_multi
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [19:0] CNT_LAST = DEB_CYCLES - 20'd1;

    state_t      state, state_nxt;
    logic [8:0]  sync1, sync2;
    logic [8:0]  cand, cand_nxt;
    logic [8:0]  out_q, out_nxt;
    logic [19:0] cnt, cnt_nxt;
    logic        chg_q, chg_nxt;
    logic        multi_q, multi_nxt;

    // {enable, switches} travel as one vector so every bit shares one settling window
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {i_en_raw, i_sw};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cand    <= '0;
            cnt     <= '0;
            out_q   <= '0;
            chg_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cand    <= cand_nxt;
            cnt     <= cnt_nxt;
            out_q   <= out_nxt;
            chg_q   <= chg_nxt;
            multi_q <= multi_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        out_nxt   = out_q;
        chg_nxt   = 1'b0;
        multi_nxt = multi_q;
        case (state)
            IDLE: begin
                if (sync2 != out_q) begin
                    cand_nxt  = sync2;
                    cnt_nxt   = '0;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (sync2 == out_q) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (sync2 != cand) begin
                    cand_nxt = sync2;
                    cnt_nxt  = '0;
                end else if (cnt < CNT_LAST) begin
                    cnt_nxt = cnt + 20'd1;
                end else begin
                    out_nxt   = cand;
                    chg_nxt   = 1'b1;
                    // x & (x-1) clears the lowest set bit; nonzero means two or more bits set
                    multi_nxt = |(cand[7:0] & (cand[7:0] - 8'd1));
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign {o_en, o_code} = out_q;
    assign o_chg          = chg_q;
    assign o_multi        = multi_q;

endmodule

// File: tb/tb_sw_debounce8.sv
// Directed bench for sw_debounce8 with DEB_CYCLES=4 (update 6 edges after first sampling).
module tb_sw_debounce8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw;
    logic       en_raw;
    logic [7:0] o_code;
    logic       o_en;
    logic       o_chg;
    logic       o_multi;

    int n_checks = 0;
    int n_fail   = 0;
    int chg_cnt  = 0;
    int chg_ref;

    sw_debounce8 #(.DEB_CYCLES(20'd4)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sw     (sw),
        .i_en_raw (en_raw),
        .o_code   (o_code),
        .o_en     (o_en),
        .o_chg    (o_chg),
        .o_multi  (o_multi)
    );

    always #5 clk = ~clk;

    // each high cycle of o_chg is seen exactly once mid-cycle
    always @(negedge clk) if (o_chg === 1'b1) chg_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] code, input logic en,
                              input logic chg, input logic multi);
        check_eq({tag, ".code"}, {24'd0, o_code}, {24'd0, code});
        check_eq({tag, ".en"}, {31'd0, o_en}, {31'd0, en});
        check_eq({tag, ".chg"}, {31'd0, o_chg}, {31'd0, chg});
        check_eq({tag, ".multi"}, {31'd0, o_multi}, {31'd0, multi});
    endtask

    initial begin
        rst_n  = 1'b1;
        sw     = 8'h00;
        en_raw = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_outs("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
        tick(2);
        check_outs("rst_held", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // quiet inputs after release: nothing moves
        tick(10);
        check_outs("idle_zero", 8'h00, 1'b0, 1'b0, 1'b0);
        check_eq("idle_no_chg", chg_cnt, 0);

        // bounce 00<->04 every 2 clocks: never survives 4 stable cycles
        for (int i = 0; i < 5; i++) begin
            sw = 8'h04;
            tick(2);
            sw = 8'h00;
            tick(2);
        end
        tick(10);
        check_outs("bounce", 8'h00, 1'b0, 1'b0, 1'b0);
        check_eq("bounce_no_chg", chg_cnt, 0);

        // clean press: 0x10 with enable
        chg_ref = chg_cnt;
        sw = 8'h10;
        en_raw = 1'b1;
        tick(6);
        check_outs("p10_early", 8'h00, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_outs("p10_upd", 8'h10, 1'b1, 1'b1, 1'b0);
        tick(1);
        check_outs("p10_after", 8'h10, 1'b1, 1'b0, 1'b0);
        check_eq("p10_one_chg", chg_cnt - chg_ref, 1);

        // enable alone drops
        chg_ref = chg_cnt;
        en_raw = 1'b0;
        tick(6);
        check_outs("en_early", 8'h10, 1'b1, 1'b0, 1'b0);
        tick(1);
        check_outs("en_upd", 8'h10, 1'b0, 1'b1, 1'b0);
        tick(5);
        check_eq("en_one_chg", chg_cnt - chg_ref, 1);

        // establish 0x01, then a short 0x02 blip restarts into 0x82
        sw = 8'h01;
        tick(10);
        check_outs("p01", 8'h01, 1'b0, 1'b0, 1'b0);
        chg_ref = chg_cnt;
        sw = 8'h02;
        tick(3);
        sw = 8'h82;
        tick(6);
        check_outs("p82_early", 8'h01, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_outs("p82_upd", 8'h82, 1'b0, 1'b1, 1'b1);
        tick(5);
        check_eq("p82_one_chg", chg_cnt - chg_ref, 1);

        // reset mid-qualification discards the candidate and starts over
        sw = 8'h00;
        tick(10);
        check_outs("p00", 8'h00, 1'b0, 1'b0, 1'b0);
        sw = 8'hFF;
        tick(4);
        rst_n = 1'b0;
        #1 check_outs("rst_wait_async", 8'h00, 1'b0, 1'b0, 1'b0);
        tick(2);
        check_outs("rst_wait_held", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        chg_ref = chg_cnt;
        tick(6);
        check_outs("pff_early", 8'h00, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_outs("pff_upd", 8'hFF, 1'b0, 1'b1, 1'b1);
        tick(3);
        check_eq("pff_one_chg", chg_cnt - chg_ref, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
